fft_stage_ctrl: RTL and testbench

Sequencer for the radix-2 butterfly datapath of the in-place FFT. On a start pulse it walks every stage and butterfly of an N-point decimation-in-time FFT and issues one butterfly per cycle. For each butterfly it emits the sample-memory read addresses for operands a and b and the twiddle ROM index feeding `cos_k`/`isin_k`. It then emits matching write-back addresses delayed by the butterfly pipeline latency, and drains the pipeline between stages so no stage reads data that is still in flight.

---
 rtl/fft_stage_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fft_stage_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_ctrl.sv
// Purpose: sequences stages and butterflies of an in-place radix-2 DIT FFT (read/twiddle/write-back addresses).
// Latency: first issue 1 cycle after start; write-back trails issue by BFU_LAT; done at LOG2N*(N/2+BFU_LAT)+1.
// Backpressure: none; one butterfly per cycle in ISSUE, BFU_LAT drain cycles between stages, start ignored when busy.
module fft_stage_ctrl #(
  parameter int LOG2N   = 4,
  parameter int BFU_LAT = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic [3:0]                            stage,
  output logic                                  rd_en,
  output logic [LOG2N-1:0]                      rd_addr_a,
  output logic [LOG2N-1:0]                      rd_addr_b,
  output logic [((LOG2N > 1) ? LOG2N-1 : 1)-1:0] tw_addr,
  output logic                                  wr_en,
  output logic [LOG2N-1:0]                      wr_addr_a,
  output logic [LOG2N-1:0]                      wr_addr_b
);

  // Butterfly index and twiddle width; at least one bit so LOG2N=1 stays legal.
  localparam int JW     = (LOG2N > 1) ? LOG2N - 1 : 1;
  localparam int HALF_N = 1 << (LOG2N - 1);

  localparam logic [JW-1:0] J_LAST = JW'(HALF_N - 1);
  localparam logic [3:0]    S_LAST = 4'(LOG2N - 1);
  localparam logic [3:0]    D_LAST = 4'(BFU_LAT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // One write-back slot: enable plus both destination indices.
  typedef struct packed {
    logic             vld;
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
  } wb_t;

  logic [1:0]       state;
  logic [3:0]       s_q;
  logic [JW-1:0]    j_q;
  logic [3:0]       dcnt;

  logic [LOG2N-1:0] j_ext;
  logic [LOG2N-1:0] pos_mask;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] grp;
  logic [LOG2N-1:0] a_calc;
  logic [LOG2N-1:0] b_calc;
  logic [3:0]       tw_sh;
  logic [JW-1:0]    tw_calc;

  wb_t              wb_in;
  wb_t              dl [BFU_LAT];

  // Address generation for butterfly j of stage s: split j into group and position within group.
  always_comb begin
    j_ext    = LOG2N'(j_q);
    pos_mask = ~({LOG2N{1'b1}} << s_q);
    pos      = j_ext & pos_mask;
    grp      = j_ext >> s_q;
    // Bit s of a is always clear, so b = a + 2^s reduces to setting that bit.
    a_calc   = ((grp << s_q) << 1) | pos;
    b_calc   = a_calc | (LOG2N'(1) << s_q);
    tw_sh    = S_LAST - s_q;
    tw_calc  = JW'(pos << tw_sh);
  end

  // Control FSM: stage/butterfly counters and the per-stage drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      s_q   <= '0;
      j_q   <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ISSUE;
            s_q   <= '0;
            j_q   <= '0;
          end
        end
        ST_ISSUE: begin
          if (j_q == J_LAST) begin
            state <= ST_DRAIN;
            dcnt  <= '0;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Exactly BFU_LAT drain cycles so the last write lands before the next stage reads.
          if (dcnt == D_LAST) begin
            if (s_q == S_LAST) begin
              state <= ST_DONE;
            end else begin
              state <= ST_ISSUE;
              s_q   <= s_q + 4'd1;
              j_q   <= '0;
            end
          end else begin
            dcnt <= dcnt + 4'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered issue-side outputs; addresses and stage hold outside ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      stage     <= '0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      busy  <= (state != ST_IDLE);
      done  <= (state == ST_DONE);
      rd_en <= (state == ST_ISSUE);
      if (state == ST_ISSUE) begin
        stage     <= s_q;
        rd_addr_a <= a_calc;
        rd_addr_b <= b_calc;
        tw_addr   <= tw_calc;
      end
    end
  end

  assign wb_in = '{vld: rd_en, a: rd_addr_a, b: rd_addr_b};

  // Write-back delay line matching the butterfly pipeline; reset flushes aborted butterflies.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BFU_LAT; i++) begin
        dl[i] <= '0;
      end
    end else begin
      dl[0] <= wb_in;
      for (int i = 1; i < BFU_LAT; i++) begin
        dl[i] <= dl[i-1];
      end
    end
  end

  assign wr_en     = dl[BFU_LAT-1].vld;
  assign wr_addr_a = dl[BFU_LAT-1].a;
  assign wr_addr_b = dl[BFU_LAT-1].b;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Purpose: checks three fft_stage_ctrl configurations against a cycle-indexed reference model.
// Latency: model predicts every output per cycle from the cycle count since the accepted start.
// Backpressure: n/a; directed start/reset scenarios followed by random start/reset traffic.
module tb_fft_stage_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v   = 3'b111;
  logic [2:0] start_v = 3'b000;
  logic [2:0] busy_v, done_v, rd_en_v, wr_en_v;
  logic [3:0] stage0, stage1, stage2;

  logic [3:0] ra0, rb0, wa0, wb0;
  logic [2:0] tw0;
  logic [0:0] ra1, rb1, wa1, wb1, tw1;
  logic [2:0] ra2, rb2, wa2, wb2;
  logic [1:0] tw2;

  fft_stage_ctrl #(.LOG2N(4), .BFU_LAT(3)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .stage(stage0), .rd_en(rd_en_v[0]), .rd_addr_a(ra0), .rd_addr_b(rb0), .tw_addr(tw0),
    .wr_en(wr_en_v[0]), .wr_addr_a(wa0), .wr_addr_b(wb0));

  fft_stage_ctrl #(.LOG2N(1), .BFU_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .stage(stage1), .rd_en(rd_en_v[1]), .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_addr(tw1),
    .wr_en(wr_en_v[1]), .wr_addr_a(wa1), .wr_addr_b(wb1));

  fft_stage_ctrl #(.LOG2N(3), .BFU_LAT(15)) u_dut2 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .stage(stage2), .rd_en(rd_en_v[2]), .rd_addr_a(ra2), .rd_addr_b(rb2), .tw_addr(tw2),
    .wr_en(wr_en_v[2]), .wr_addr_a(wa2), .wr_addr_b(wb2));

  int lg [3] = '{4, 1, 3};
  int lt [3] = '{3, 1, 15};

  // Reference state: cycle index since accepted start (-1 = idle), held issue values, issue history.
  int cyc [3];
  int last_s [3], last_a [3], last_b [3], last_tw [3];
  int h_en [3][16], h_a [3][16], h_b [3][16];
  int e_busy [3], e_done [3], e_rd [3], e_wr [3], e_wa [3], e_wb [3];

  int n_cmp = 0;
  int n_bad = 0;
  int cur_d = 0;
  int tick_no = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL dut%0d tick %0d %s: got %0d expected %0d", cur_d, tick_no, tag, act, exp);
    end
  endtask

  task automatic model_edge(input int d, input bit st, input bit rs);
    int n, p, tot, s, j, half, pos, grp;
    n   = 1 << lg[d];
    p   = n / 2 + lt[d];
    tot = lg[d] * p;
    if (rs) begin
      cyc[d] = -1;
      last_s[d] = 0; last_a[d] = 0; last_b[d] = 0; last_tw[d] = 0;
      for (int i = 0; i < 16; i++) begin
        h_en[d][i] = 0; h_a[d][i] = 0; h_b[d][i] = 0;
      end
    end else if ((cyc[d] < 0 || cyc[d] == tot + 1) && st) begin
      cyc[d] = 0;
    end else if (cyc[d] == tot + 1) begin
      cyc[d] = -1;
    end else if (cyc[d] >= 0) begin
      cyc[d]++;
    end
    e_busy[d] = (cyc[d] >= 1 && cyc[d] <= tot + 1) ? 1 : 0;
    e_done[d] = (cyc[d] == tot + 1) ? 1 : 0;
    e_rd[d]   = 0;
    if (cyc[d] >= 1 && cyc[d] <= tot && ((cyc[d] - 1) % p) < n / 2) begin
      s    = (cyc[d] - 1) / p;
      j    = (cyc[d] - 1) % p;
      half = 1 << s;
      pos  = j % half;
      grp  = j / half;
      last_a[d]  = grp * 2 * half + pos;
      last_b[d]  = last_a[d] + half;
      last_tw[d] = pos * (n / 2) / half;
      last_s[d]  = s;
      e_rd[d]    = 1;
    end
    for (int i = 15; i > 0; i--) begin
      h_en[d][i] = h_en[d][i-1]; h_a[d][i] = h_a[d][i-1]; h_b[d][i] = h_b[d][i-1];
    end
    h_en[d][0] = e_rd[d]; h_a[d][0] = last_a[d]; h_b[d][0] = last_b[d];
    e_wr[d] = h_en[d][lt[d]];
    e_wa[d] = h_a[d][lt[d]];
    e_wb[d] = h_b[d][lt[d]];
  endtask

  task automatic compare_dut(input int d);
    logic [31:0] st, ra, rb, tw, wa, wb;
    case (d)
      0:       begin st = 32'(stage0); ra = 32'(ra0); rb = 32'(rb0); tw = 32'(tw0); wa = 32'(wa0); wb = 32'(wb0); end
      1:       begin st = 32'(stage1); ra = 32'(ra1); rb = 32'(rb1); tw = 32'(tw1); wa = 32'(wa1); wb = 32'(wb1); end
      default: begin st = 32'(stage2); ra = 32'(ra2); rb = 32'(rb2); tw = 32'(tw2); wa = 32'(wa2); wb = 32'(wb2); end
    endcase
    cur_d = d;
    chk("busy",      32'(busy_v[d]),  e_busy[d]);
    chk("done",      32'(done_v[d]),  e_done[d]);
    chk("stage",     st,              last_s[d]);
    chk("rd_en",     32'(rd_en_v[d]), e_rd[d]);
    chk("rd_addr_a", ra,              last_a[d]);
    chk("rd_addr_b", rb,              last_b[d]);
    chk("tw_addr",   tw,              last_tw[d]);
    chk("wr_en",     32'(wr_en_v[d]), e_wr[d]);
    chk("wr_addr_a", wa,              e_wa[d]);
    chk("wr_addr_b", wb,              e_wb[d]);
  endtask

  task automatic tick(input logic [2:0] st, input logic [2:0] rs);
    start_v = st;
    rst_v   = rs;
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_edge(d, st[d], rs[d]);
    @(negedge clk);
    tick_no++;
    for (int d = 0; d < 3; d++) compare_dut(d);
  endtask

  int done_at [3];
  int wcount [3];
  int exp_done [3] = '{45, 3, 58};
  int exp_wr   [3] = '{32, 1, 12};
  logic [2:0] rnd_st, rnd_rs;

  initial begin
    for (int d = 0; d < 3; d++) cyc[d] = -1;

    // Reset state
    tick(3'b000, 3'b111);
    tick(3'b000, 3'b111);

    // Single start at edge 0; record done cycle and write count per configuration
    for (int d = 0; d < 3; d++) begin done_at[d] = -1; wcount[d] = 0; end
    tick(3'b111, 3'b000);
    for (int k = 1; k <= 70; k++) begin
      tick(3'b000, 3'b000);
      for (int d = 0; d < 3; d++) begin
        if (done_v[d] === 1'b1 && done_at[d] < 0) done_at[d] = k;
        if (wr_en_v[d] === 1'b1) wcount[d]++;
      end
    end
    for (int d = 0; d < 3; d++) begin
      cur_d = d;
      chk("done_cycle", done_at[d], exp_done[d]);
      chk("write_count", wcount[d], exp_wr[d]);
    end

    // start held high: back-to-back transforms, extra pulses ignored
    for (int k = 0; k < 200; k++) tick(3'b111, 3'b000);
    for (int k = 0; k < 80; k++) tick(3'b000, 3'b000);

    // Mid-transform reset at cycle 20, fresh start at cycle 25
    tick(3'b111, 3'b000);
    for (int k = 1; k < 20; k++) tick(3'b000, 3'b000);
    tick(3'b000, 3'b111);
    for (int k = 21; k < 25; k++) tick(3'b000, 3'b000);
    tick(3'b111, 3'b000);
    for (int k = 0; k < 70; k++) tick(3'b000, 3'b000);

    // Random start/reset traffic
    for (int k = 0; k < 3000; k++) begin
      for (int d = 0; d < 3; d++) begin
        rnd_st[d] = ($urandom_range(0, 9) == 0);
        rnd_rs[d] = ($urandom_range(0, 199) == 0);
      end
      tick(rnd_st, rnd_rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
